// File: rtl/ot_write.sv
// ot_write: output-SRAM writer. Accepts result beats from a valid/ready
// stream and writes them to consecutive SRAM words 0..ADDR_FINAL-1, then
// pulses done so the downstream reader can be launched.
// Optional build macro: OTW_LAST_CHECK_EN enables the sticky err_last check
// of the producer's in_last marker against the final-address position.
//
// Stream handshake: a beat transfers in any cycle where in_valid and
// in_ready are both high at the rising clock edge; in_ready never depends
// on in_valid, and the producer holds in_valid/in_data until the transfer.
module ot_write #(
  parameter int ADDR_FINAL = 20,
  parameter int DATA_BITS  = 64,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 hold,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 cen_otsr,
  output logic                 wen_otsr,
  output logic [ADDR_BITS-1:0] addr_otsr,
  output logic [DATA_BITS-1:0] data_to_sram,
  output logic                 err_last,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(ADDR_FINAL - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ADDR_BITS-1:0]   r_cnt_addr;
  logic                   r_cen;
  logic                   r_wen;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DATA_BITS-1:0]   r_data;
  logic                   w_accept;
  logic                   w_is_last;
  logic                   w_launch;

  assign in_ready     = (r_state == S_WRITE) & ~hold;
  assign w_accept     = in_valid & in_ready;
  assign w_is_last    = (r_cnt_addr == LAST_ADDR);
  assign w_launch     = (r_state == S_IDLE) & start;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign cen_otsr     = r_cen;
  assign wen_otsr     = r_wen;
  assign addr_otsr    = r_addr;
  assign data_to_sram = r_data;
  assign dbg_state    = r_state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: one run is IDLE -> WRITE (ADDR_FINAL beats) -> FLUSH -> DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_WRITE;
      S_WRITE: if (w_accept && w_is_last) w_next_state = S_FLUSH;
      S_FLUSH: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Write address counter: restarts on launch, advances per accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_addr <= '0;
    end else if (w_launch) begin
      r_cnt_addr <= '0;
    end else if (w_accept) begin
      if (w_is_last) r_cnt_addr <= '0;
      else           r_cnt_addr <= r_cnt_addr + 1'b1;
    end
  end

  // Registered SRAM port: one write cycle per accepted beat, idle otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cen  <= 1'b1;
      r_wen  <= 1'b1;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_cen  <= 1'b0;
      r_wen  <= 1'b0;
      r_addr <= r_cnt_addr;
      r_data <= in_data;
    end else begin
      r_cen  <= 1'b1;
      r_wen  <= 1'b1;
    end
  end

`ifdef OTW_LAST_CHECK_EN
  logic r_err_last;

  // Sticky flag: in_last must be high exactly on the beat for the final address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_last <= 1'b0;
    end else if (w_launch) begin
      r_err_last <= 1'b0;
    end else if (w_accept && (in_last != w_is_last)) begin
      r_err_last <= 1'b1;
    end
  end

  assign err_last = r_err_last;
`else
  logic w_unused_last;

  assign w_unused_last = in_last;
  assign err_last      = 1'b0;
`endif

endmodule

// File: tb/tb_ot_write.sv
// tb_ot_write: directed bench for ot_write. The driver pushes the expected
// {addr, data} of every beat it hands over; a negedge monitor pops and
// compares whenever the SRAM port shows a write.
module tb_ot_write;

  localparam int AF = 20;
  localparam int DW = 64;
  localparam int AW = 10;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          hold;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] in_data;
  logic          cen_otsr;
  logic          wen_otsr;
  logic [AW-1:0] addr_otsr;
  logic [DW-1:0] data_to_sram;
  logic          err_last;
  logic [1:0]    dbg_state;

  int total;
  int bad;
  logic [AW+DW-1:0] exp_q[$];

  ot_write #(.ADDR_FINAL(AF), .DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .hold         (hold),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_data      (in_data),
    .cen_otsr     (cen_otsr),
    .wen_otsr     (wen_otsr),
    .addr_otsr    (addr_otsr),
    .data_to_sram (data_to_sram),
    .err_last     (err_last),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset && (cen_otsr == 1'b0)) begin
      check("wen_on_write", DW'(wen_otsr), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty queue", addr_otsr, data_to_sram);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("write_addr", DW'(addr_otsr), DW'(e[AW+DW-1:DW]));
        check("write_data", data_to_sram, e[DW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end at posedge+1.
  task automatic do_reset();
    reset    = 1'b0;
    start    = 1'b0;
    hold     = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cen",   DW'(cen_otsr), 64'd1);
    check("rst_wen",   DW'(wen_otsr), 64'd1);
    check("rst_addr",  DW'(addr_otsr), 64'd0);
    check("rst_data",  data_to_sram, 64'd0);
    check("rst_busy",  DW'(busy), 64'd0);
    check("rst_done",  DW'(done), 64'd0);
    check("rst_ready", DW'(in_ready), 64'd0);
    check("rst_err",   DW'(err_last), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy",  DW'(busy), 64'd1);
    check("start_ready", DW'(in_ready), 64'd1);
    check("start_err",   DW'(err_last), 64'd0);
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input int addr, input logic last);
    int budget;
    budget   = 50;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget--;
      if (budget == 0) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: in_ready never rose for addr %0d", addr);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back({AW'(addr), data});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the final accept edge: FLUSH, then DONE, then IDLE.
  task automatic finish_run();
    check("flush_done",  DW'(done), 64'd0);
    check("flush_busy",  DW'(busy), 64'd1);
    check("flush_ready", DW'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("done_pulse", DW'(done), 64'd1);
    check("done_busy",  DW'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("idle_done", DW'(done), 64'd0);
    check("idle_busy", DW'(busy), 64'd0);
    check("queue_drained", DW'(exp_q.size()), 64'd0);
  endtask

  // One complete run. gap_mask[i]: idle cycle before beat i; hold_after: beat
  // after which hold is raised for 3 cycles; restart_at: beat carrying a stray
  // start pulse; bad_last_at: beat whose in_last is wrong.
  task automatic run_full(input logic [DW-1:0] base, input logic [31:0] gap_mask,
                          input int hold_after, input int restart_at, input int bad_last_at);
    start_run();
    for (int i = 0; i < AF; i++) begin
      logic lst;
      if (gap_mask[i]) begin
        @(posedge clk);
        #1;
      end
      if (i == restart_at) start = 1'b1;
      lst = (i == AF - 1);
      if (i == bad_last_at) lst = ~lst;
      send_beat(base + DW'(i), i, lst);
      if (i == restart_at) begin
        start = 1'b0;
        check("restart_busy", DW'(busy), 64'd1);
      end
      if (i == bad_last_at) begin
`ifdef OTW_LAST_CHECK_EN
        check("err_set", DW'(err_last), 64'd1);
`else
        check("err_tied", DW'(err_last), 64'd0);
`endif
      end
      if (i == hold_after) begin
        hold     = 1'b1;
        in_valid = 1'b1;
        in_data  = base + DW'(i + 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("hold_ready", DW'(in_ready), 64'd0);
          if (k > 0) check("hold_cen", DW'(cen_otsr), 64'd1);
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
      end
    end
    finish_run();
`ifdef OTW_LAST_CHECK_EN
    check("err_end", DW'(err_last), (bad_last_at >= 0) ? 64'd1 : 64'd0);
`else
    check("err_end", DW'(err_last), 64'd0);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    do_reset();

    // Full back-to-back run, addr 0..19, data 0x100..0x113.
    run_full(64'h100, 32'h0, -1, -1, -1);

    // Gappy source: idle cycles before beats 3, 4 and 11.
    run_full(64'h200, 32'h0000_0818, -1, -1, -1);

    // Arbitration stall after beat 7.
    run_full(64'h300, 32'h0, 7, -1, -1);

    // Stray start at beat 5; then a fresh run from addr 0.
    run_full(64'h400, 32'h0, -1, 5, -1);
    run_full(64'h500, 32'h0, -1, -1, -1);

    // Wrong in_last on beat 10; the next run's start must clear err_last.
    run_full(64'h600, 32'h0, -1, -1, 10);
    run_full(64'h700, 32'h0, -1, -1, -1);

    // Async reset mid-run after beat 5.
    start_run();
    for (int i = 0; i <= 5; i++) send_beat(64'h800 + DW'(i), i, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_cen",   DW'(cen_otsr), 64'd1);
    check("arst_wen",   DW'(wen_otsr), 64'd1);
    check("arst_ready", DW'(in_ready), 64'd1 - 64'd1);
    check("arst_busy",  DW'(busy), 64'd0);
    check("arst_done",  DW'(done), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_full(64'h900, 32'h0, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ot_write.md
Name: ot_write

Overview:
Output-SRAM writer. It sits directly upstream of the output-SRAM reader and fills the 64-bit output SRAM with result beats from a valid/ready stream.
- Address space: ADDR_FINAL words, written sequentially from address 0.
- Control: start/busy/done handshake so the top-level sequencer can launch the reader once the buffer is complete.
- SRAM port outputs are registered; one write per accepted beat.

Parameters:
ADDR_FINAL, 20, number of words per run; legal range 1..2^ADDR_BITS
DATA_BITS, 64, data width of stream and SRAM
ADDR_BITS, 10, SRAM address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle launch pulse; ignored unless IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE state
hold  input  1  SRAM arbitration stall; forces in_ready low
in_valid  input  1  stream beat valid
in_ready  output  1  block can accept a beat
in_last  input  1  producer end-of-run marker (used only with OTW_LAST_CHECK_EN)
in_data  input  DATA_BITS  result beat
cen_otsr  output  1  SRAM chip enable, active-low, registered
wen_otsr  output  1  SRAM write enable, active-low, registered
addr_otsr  output  ADDR_BITS  SRAM address, registered
data_to_sram  output  DATA_BITS  SRAM write data, registered
err_last  output  1  sticky last-marker mismatch flag

Behaviour:
- Reset (reset=0, async): state IDLE, cnt_addr=0, cen_otsr=1, wen_otsr=1, addr_otsr=0, data_to_sram=0, err_last=0. Derived outputs busy=0, done=0, in_ready=0.
- FSM, registered:
  - IDLE: start -> WRITE, cnt_addr=0.
  - WRITE: on accept with cnt_addr==ADDR_FINAL-1 -> FLUSH; otherwise stay.
  - FLUSH: -> DONE unconditionally.
  - DONE: -> IDLE.
- in_ready = (state==WRITE) & ~hold. This is combinational from registered state plus hold, and does not depend on in_valid.
- accept = in_valid & in_ready.
- Accept in cycle T:
  - at the T/T+1 edge, cen_otsr<=0, wen_otsr<=0, addr_otsr<=cnt_addr, data_to_sram<=in_data;
  - cnt_addr increments; it clears to 0 when it was ADDR_FINAL-1.
- No accept: cen_otsr<=1, wen_otsr<=1; addr_otsr and data_to_sram hold their previous values.
- Write latency is exactly 1 cycle from accept. Back-to-back accepts give back-to-back writes, with no bubbles required.
- The last accept in cycle T gives: FLUSH in T+1 (last write visible on ports), DONE with done=1 in T+2, IDLE in T+3.
- busy is high from the cycle after the start edge through DONE inclusive.
- start while busy: ignored; no restart, counter unaffected.
- hold during WRITE: no beats accepted, no SRAM writes, cnt_addr frozen. hold has no effect in FLUSH/DONE; the last write is never stalled.
- ADDR_FINAL=1: one accept moves WRITE -> FLUSH directly.
- Address wraps only via the run end; cnt_addr never exceeds ADDR_FINAL-1.
- Reset mid-run: immediate async return to the reset values. A partially written buffer is abandoned; the next start rewrites from address 0.

Optional Feature:
Macro OTW_LAST_CHECK_EN.
- Defined: err_last is set on the cycle after any accept where in_last != (cnt_addr==ADDR_FINAL-1). It stays set (sticky) until the next accepted start or reset.
- Not defined: in_last is ignored and err_last is tied 0.
- Write behaviour is identical in both builds.

Test Plan:
1. Full run: start, then in_valid held high with data 0x100+i for 20 beats -> cen_otsr/wen_otsr low for 20 consecutive cycles, addr 0..19, data 0x100..0x113; done=1 exactly 2 cycles after the 20th accept; busy drops the cycle after done.
2. Gappy source: in_valid low on beats 3, 4 and 11 (one idle cycle each) -> no write on gap cycles; addresses remain contiguous 0..19; done still 2 cycles after the final accept.
3. Arbitration stall: hold=1 for 3 cycles after beat 7 is accepted -> in_ready=0 and cen_otsr=1 for those cycles; the next accepted beat writes addr 8.
4. Restart handling: pulse start at beat 5 of a run -> ignored, run ends at addr 19. A second start after done writes from addr 0 again.
5. Async reset: drop reset mid-cycle after beat 5 -> cen_otsr=1, wen_otsr=1, in_ready=0, busy=0 before the next clock edge; a new run's first write is at addr 0.
6. With OTW_LAST_CHECK_EN: in_last=1 on beat 10 -> err_last=1 from the next cycle until the next start. Correct in_last on beat 19 only -> err_last stays 0. Without the macro, err_last=0 throughout.
